// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_ctrl_pkg;
    localparam int XLEN           = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_RUN
    } state_e;
endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// Packs accepted loader bytes little-endian into a 32-bit word.
// word_full_o flags the byte that completes the word.
module byte_packer
    import imem_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            byte_vld_i,
    input  logic [7:0]      byte_i,
    output logic [XLEN-1:0] word_o,
    output logic            word_full_o
);
    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [XLEN-1:0] word_q, word_d;

    // Every lane is overwritten once per word, so the lane register needs no clear.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        if (clr_i) begin
            byte_cnt_d = '0;
        end else if (byte_vld_i) begin
            word_d[8*byte_cnt_q +: 8] = byte_i;
            byte_cnt_d                = byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = byte_vld_i && (byte_cnt_q == CW'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_load_ctrl.sv
// Owns the instruction memory write port: streams loader bytes into words,
// stalls the core during a load, then clears the PC and releases it.
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_data,
    output logic                     ld_ready,
    input  logic [XLEN-1:0]          fetch_addr,
    output logic [XLEN-1:0]          mem_raddr,
    output logic                     mem_we,
    output logic [$clog2(WORDS)-1:0] mem_waddr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic                     core_stall,
    output logic                     pc_clear,
    output logic                     load_done,
    output logic                     err_misalign
);
    localparam int     AW        = $clog2(WORDS);
    localparam state_e RST_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

    state_e          state_q, state_d;
    logic [AW-1:0]   word_cnt_q, word_cnt_d;
    logic            done_q, done_d;
    logic            mis_q, mis_d;
    logic            accept, restart, word_full;
    logic [XLEN-1:0] packed_word;

    assign accept  = ld_valid && ld_ready;
    assign restart = (state_q == ST_RUN) && ld_start;

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (restart),
        .byte_vld_i  (accept),
        .byte_i      (ld_data),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        done_d     = done_q;
        mis_d      = mis_q;
        case (state_q)
            ST_LOAD:  if (word_full) state_d = ST_WRITE;
            ST_WRITE: begin
                if (word_cnt_q == AW'(WORDS - 1)) begin
                    state_d    = ST_DONE;
                    word_cnt_d = '0;
                end else begin
                    state_d    = ST_LOAD;
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fetch_addr[1:0] != 2'b00) mis_d = 1'b1;
                if (ld_start) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
        end
    end

    // Outputs decode straight from the registered state.
    assign ld_ready     = (state_q == ST_LOAD);
    assign core_stall   = (state_q != ST_RUN);
    assign mem_we       = (state_q == ST_WRITE);
    assign pc_clear     = (state_q == ST_DONE);
    assign mem_raddr    = (state_q == ST_RUN) ? fetch_addr : '0;
    assign mem_waddr    = word_cnt_q;
    assign mem_wdata    = mem_we ? packed_word : '0;
    assign load_done    = (state_q == ST_RUN) && done_q;
    assign err_misalign = mis_q;
endmodule
